// File: rtl/mci_arbiter.sv
// mci_arbiter: two-master round-robin arbiter for the GMAC MCI register port.
// Master 0 is the speed-control MCI master and master 1 is the host bridge.
// One transaction is in flight at a time, and the MCI outputs are registered.
// A watchdog aborts any transaction the MAC never acknowledges and reports it
// to the requesting master as an error.
module mci_arbiter #(
   parameter int TIMEOUT_CYC = 1023,
   parameter int CNT_W       = 10,
   parameter int RECOVER_CYC = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_m0_val,
   input  logic [31:0] i_m0_wdata,
   input  logic [3:0]  i_m0_be,
   input  logic [13:0] i_m0_addr,
   input  logic        i_m0_rdwn,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   output logic [31:0] o_m0_rdata,
   input  logic        i_m1_val,
   input  logic [31:0] i_m1_wdata,
   input  logic [3:0]  i_m1_be,
   input  logic [13:0] i_m1_addr,
   input  logic        i_m1_rdwn,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [31:0] o_m1_rdata,
   output logic        o_mci_val,
   output logic [31:0] o_mci_wdata,
   output logic [3:0]  o_mci_be,
   output logic [13:0] o_mci_addr,
   output logic        o_mci_rdwn,
   input  logic        i_mci_ack,
   input  logic [31:0] i_mci_rdata,
   output logic        o_busy,
   output logic [7:0]  o_err_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2, ABORT = 2'd3} state_t;

   // The timer starts at 0 on the grant edge, so comparing against N-1 gives
   // o_mci_val exactly TIMEOUT_CYC cycles high; the same register then paces ABORT.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYC - 1);

   state_t           state_reg, state_next;
   logic             last_grant_reg;   // also identifies the owner while in GRANT
   logic [CNT_W-1:0] timer_reg;
   logic             mci_val_reg;
   logic [31:0]      mci_wdata_reg;
   logic [3:0]       mci_be_reg;
   logic [13:0]      mci_addr_reg;
   logic             mci_rdwn_reg;
   logic [7:0]       err_cnt_reg;
   logic             ack_reg   [2];
   logic             err_reg   [2];
   logic [31:0]      rdata_reg [2];

   logic             grant_sel, load, fin_ok, fin_abort;
   logic [31:0]      sel_wdata;
   logic [3:0]       sel_be;
   logic [13:0]      sel_addr;
   logic             sel_rdwn;

   // Next state and control strobes; ack beats timeout when both land together
   always_comb begin
      state_next = state_reg;
      grant_sel  = 1'b0;
      load       = 1'b0;
      fin_ok     = 1'b0;
      fin_abort  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_m0_val || i_m1_val) begin
               load       = 1'b1;
               grant_sel  = (i_m0_val && i_m1_val) ? ~last_grant_reg : i_m1_val;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (i_mci_ack) begin
               fin_ok     = 1'b1;
               state_next = DONE;
            end else if (timer_reg == TIMEOUT_LAST) begin
               fin_abort  = 1'b1;
               state_next = ABORT;
            end
         end
         DONE:    state_next = IDLE;
         ABORT:   if (timer_reg == RECOVER_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Payload of the master selected this cycle
   always_comb begin
      sel_wdata = grant_sel ? i_m1_wdata : i_m0_wdata;
      sel_be    = grant_sel ? i_m1_be    : i_m0_be;
      sel_addr  = grant_sel ? i_m1_addr  : i_m0_addr;
      sel_rdwn  = grant_sel ? i_m1_rdwn  : i_m0_rdwn;
   end

   // State register and round-robin pointer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         if (load) last_grant_reg <= grant_sel;
      end
   end

   // Watchdog timer in GRANT, recovery counter in ABORT
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         timer_reg <= '0;
      end else if (load || fin_abort) begin
         timer_reg <= '0;
      end else if (state_reg == GRANT || state_reg == ABORT) begin
         timer_reg <= timer_reg + CNT_W'(1);
      end
   end

   // Registered MCI request toward the MAC; payload holds until the next grant
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mci_val_reg   <= 1'b0;
         mci_wdata_reg <= '0;
         mci_be_reg    <= '0;
         mci_addr_reg  <= '0;
         mci_rdwn_reg  <= 1'b0;
      end else if (load) begin
         mci_val_reg   <= 1'b1;
         mci_wdata_reg <= sel_wdata;
         mci_be_reg    <= sel_be;
         mci_addr_reg  <= sel_addr;
         mci_rdwn_reg  <= sel_rdwn;
      end else if (fin_ok || fin_abort) begin
         mci_val_reg   <= 1'b0;
      end
   end

   // Saturating timeout counter, cleared only by reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_cnt_reg <= '0;
      end else if (fin_abort && err_cnt_reg != 8'hFF) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   // Per-master completion pulse, error flag and held read data
   for (genvar gi = 0; gi < 2; gi++) begin : g_master
      logic is_owner;
      assign is_owner = (last_grant_reg == 1'(gi));

      // Ack/err pulse for one cycle; rdata captured on reads, zeroed on abort
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            ack_reg[gi]   <= 1'b0;
            err_reg[gi]   <= 1'b0;
            rdata_reg[gi] <= '0;
         end else begin
            ack_reg[gi] <= (fin_ok || fin_abort) && is_owner;
            err_reg[gi] <= fin_abort && is_owner;
            if (fin_abort && is_owner) begin
               rdata_reg[gi] <= '0;
            end else if (fin_ok && is_owner && mci_rdwn_reg) begin
               rdata_reg[gi] <= i_mci_rdata;
            end
         end
      end
   end

   assign o_m0_ack    = ack_reg[0];
   assign o_m0_err    = err_reg[0];
   assign o_m0_rdata  = rdata_reg[0];
   assign o_m1_ack    = ack_reg[1];
   assign o_m1_err    = err_reg[1];
   assign o_m1_rdata  = rdata_reg[1];
   assign o_mci_val   = mci_val_reg;
   assign o_mci_wdata = mci_wdata_reg;
   assign o_mci_be    = mci_be_reg;
   assign o_mci_addr  = mci_addr_reg;
   assign o_mci_rdwn  = mci_rdwn_reg;
   assign o_busy      = (state_reg != IDLE);
   assign o_err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_mci_arbiter.sv
// tb_mci_arbiter: directed stimulus for mci_arbiter with a transaction-level
// reference model checked every cycle, plus hand-computed spot checks.
module tb_mci_arbiter;

   localparam int TO = 15;
   localparam int RC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_val = 1'b0, m1_val = 1'b0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_be = '0, m1_be = '0;
   logic [13:0] m0_addr = '0, m1_addr = '0;
   logic        m0_rdwn = 1'b0, m1_rdwn = 1'b0;
   logic        mci_ack = 1'b0;
   logic [31:0] mci_rdata = 32'hDEAD_BEEF;

   logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic [31:0] o_m0_rdata, o_m1_rdata;
   logic        o_mci_val, o_mci_rdwn, o_busy;
   logic [31:0] o_mci_wdata;
   logic [3:0]  o_mci_be;
   logic [13:0] o_mci_addr;
   logic [7:0]  o_err_cnt;

   mci_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(10), .RECOVER_CYC(RC)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_val(m0_val), .i_m0_wdata(m0_wdata), .i_m0_be(m0_be), .i_m0_addr(m0_addr),
      .i_m0_rdwn(m0_rdwn), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
      .i_m1_val(m1_val), .i_m1_wdata(m1_wdata), .i_m1_be(m1_be), .i_m1_addr(m1_addr),
      .i_m1_rdwn(m1_rdwn), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
      .o_mci_val(o_mci_val), .o_mci_wdata(o_mci_wdata), .o_mci_be(o_mci_be),
      .o_mci_addr(o_mci_addr), .o_mci_rdwn(o_mci_rdwn), .i_mci_ack(mci_ack),
      .i_mci_rdata(mci_rdata), .o_busy(o_busy), .o_err_cnt(o_err_cnt)
   );

   initial forever #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model (transaction level) ----------------
   // owner: -1 when nobody holds the port; cool: cycles the port stays blocked
   // after a completion (1 after a normal ack, RC after an abort).
   int          owner, age, cool, last;
   logic        e_val, e_rdwn;
   logic [31:0] e_wdata;
   logic [3:0]  e_be;
   logic [13:0] e_addr;
   logic        e_ack [2];
   logic        e_err [2];
   logic [31:0] e_rdata [2];
   logic [7:0]  e_cnt;

   task automatic mdl_reset();
      owner = -1; age = 0; cool = 0; last = 1;
      e_val = 0; e_rdwn = 0; e_wdata = '0; e_be = '0; e_addr = '0; e_cnt = '0;
      for (int i = 0; i < 2; i++) begin
         e_ack[i] = 0; e_err[i] = 0; e_rdata[i] = '0;
      end
   endtask

   task automatic mdl_step();
      int w;
      e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
      if (cool > 0) begin
         cool--;
      end else if (owner >= 0) begin
         age++;
         if (mci_ack) begin
            e_val = 0; e_ack[owner] = 1;
            if (e_rdwn) e_rdata[owner] = mci_rdata;
            owner = -1; cool = 1;
         end else if (age == TO) begin
            e_val = 0; e_ack[owner] = 1; e_err[owner] = 1; e_rdata[owner] = '0;
            if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            owner = -1; cool = RC;
         end
      end else begin
         w = -1;
         if (m0_val && m1_val) w = 1 - last;
         else if (m0_val)      w = 0;
         else if (m1_val)      w = 1;
         if (w == 0) begin
            e_wdata = m0_wdata; e_be = m0_be; e_addr = m0_addr; e_rdwn = m0_rdwn;
         end else if (w == 1) begin
            e_wdata = m1_wdata; e_be = m1_be; e_addr = m1_addr; e_rdwn = m1_rdwn;
         end
         if (w >= 0) begin
            e_val = 1; owner = w; age = 0; last = w;
         end
      end
   endtask

   initial begin
      mdl_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) mdl_reset();
         else     mdl_step();
      end
   end

   // Compare every output against the model away from the active edge
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("mci_val",   o_mci_val,   e_val);
         check("mci_wdata", o_mci_wdata, e_wdata);
         check("mci_be",    o_mci_be,    e_be);
         check("mci_addr",  o_mci_addr,  e_addr);
         check("mci_rdwn",  o_mci_rdwn,  e_rdwn);
         check("m0_ack",    o_m0_ack,    e_ack[0]);
         check("m0_err",    o_m0_err,    e_err[0]);
         check("m0_rdata",  o_m0_rdata,  e_rdata[0]);
         check("m1_ack",    o_m1_ack,    e_ack[1]);
         check("m1_err",    o_m1_err,    e_err[1]);
         check("m1_rdata",  o_m1_rdata,  e_rdata[1]);
         check("busy",      o_busy,      (owner >= 0) || (cool > 0));
         check("err_cnt",   o_err_cnt,   e_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   // One clock; masters drop their request once they see their ack
   task automatic step();
      @(posedge clk); #1;
      if (o_m0_ack) m0_val = 1'b0;
      if (o_m1_ack) m1_val = 1'b0;
   endtask

   task automatic wait_val();
      int n = 0;
      while (!o_mci_val && n < 40) begin
         step(); n++;
      end
      check("wait_mci_val", o_mci_val, 1'b1);
   endtask

   // Wait for a grant, hold ack off for dly cycles, ack once; report who got the ack
   task automatic serve(input int dly, input logic [31:0] rd, output int who, output logic [63:0] pl);
      who = -1;
      wait_val();
      pl = {13'b0, o_mci_rdwn, o_mci_addr, o_mci_be, o_mci_wdata};
      if (!o_mci_val) return;
      repeat (dly) step();
      mci_ack = 1'b1; mci_rdata = rd;
      step();
      mci_ack = 1'b0; mci_rdata = 32'hDEAD_BEEF;
      if (o_m0_ack)      who = 0;
      else if (o_m1_ack) who = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int          who;
      logic [63:0] pl;
      logic [63:0] exp_pl;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",    o_busy,    1'b0);
      check("rst_mci_val", o_mci_val, 1'b0);
      check("rst_err_cnt", o_err_cnt, 8'd0);
      rst = 1'b0;
      cmp_en = 1'b1;
      step();

      // Simultaneous requests after reset: m0 first, then m1; repeat pair
      m0_val = 1; m0_addr = 14'h0100; m0_rdwn = 0; m0_wdata = 32'h0000_1234; m0_be = 4'h3;
      m1_val = 1; m1_addr = 14'h0200; m1_rdwn = 1; m1_wdata = 32'h0;         m1_be = 4'hF;
      serve(1, 32'h1111_0000, who, pl);
      check("t2_p1_first",      who, 0);
      check("t2_p1_first_addr", pl[49:36], 14'h0100);
      serve(1, 32'h1111_0001, who, pl);
      check("t2_p1_second",      who, 1);
      check("t2_p1_second_addr", pl[49:36], 14'h0200);
      check("t2_p1_m1_rdata",    o_m1_rdata, 32'h1111_0001);
      check("t2_m0_write_rdata", o_m0_rdata, 32'h0);
      repeat (2) step();
      m0_val = 1; m0_addr = 14'h0104; m0_rdwn = 1;
      m1_val = 1; m1_addr = 14'h0204; m1_rdwn = 1;
      serve(0, 32'hAAAA_0002, who, pl);
      check("t2_p2_first", who, 0);
      serve(2, 32'h2222_0002, who, pl);
      check("t2_p2_second", who, 1);
      check("t2_p2_m1_rdata", o_m1_rdata, 32'h2222_0002);
      repeat (2) step();

      // Single m0 read, MAC acks 3 cycles after o_mci_val
      m0_val = 1; m0_addr = 14'h0004; m0_rdwn = 1; m0_wdata = 32'h0; m0_be = 4'hF;
      serve(3, 32'h0000_0140, who, pl);
      check("t1_ack_latency", who, 0);
      check("t1_rdata",       o_m0_rdata, 32'h0000_0140);
      check("t1_err",         o_m0_err, 1'b0);
      repeat (2) step();

      // m1 write: exact payload on the MCI port, m1 read data untouched
      m1_val = 1; m1_addr = 14'h0010; m1_rdwn = 0; m1_wdata = 32'hA5A5_0001; m1_be = 4'hF;
      exp_pl = {13'b0, 1'b0, 14'h0010, 4'hF, 32'hA5A5_0001};
      serve(4, 32'hFFFF_0003, who, pl);
      check("t3_payload",  pl, exp_pl);
      check("t3_who",      who, 1);
      check("t3_m1_rdata", o_m1_rdata, 32'h2222_0002);
      repeat (2) step();

      // Timeout: MAC never acks, abort after TO cycles, late ack ignored
      m0_val = 1; m0_addr = 14'h0020; m0_rdwn = 1;
      wait_val();
      repeat (TO - 1) step();
      check("t4_val_last_cycle", o_mci_val, 1'b1);
      step();
      check("t4_val_dropped", o_mci_val, 1'b0);
      check("t4_ack",         o_m0_ack, 1'b1);
      check("t4_err",         o_m0_err, 1'b1);
      check("t4_rdata",       o_m0_rdata, 32'h0);
      check("t4_err_cnt",     o_err_cnt, 8'd1);
      mci_ack = 1'b1; mci_rdata = 32'h7777_7777;
      step();
      mci_ack = 1'b0; mci_rdata = 32'hDEAD_BEEF;
      check("t4_late_ack_m0", o_m0_ack, 1'b0);
      check("t4_late_rdata",  o_m0_rdata, 32'h0);
      check("t4_abort_busy",  o_busy, 1'b1);
      repeat (RC + 1) step();
      check("t4_idle_again",  o_busy, 1'b0);

      // Ack on the exact timeout cycle wins
      m0_val = 1; m0_addr = 14'h0024; m0_rdwn = 1;
      serve(TO - 1, 32'h5555_AAAA, who, pl);
      check("t5_who",     who, 0);
      check("t5_err",     o_m0_err, 1'b0);
      check("t5_rdata",   o_m0_rdata, 32'h5555_AAAA);
      check("t5_err_cnt", o_err_cnt, 8'd1);
      repeat (2) step();

      // Reset while granted, then a fresh m1 read
      m0_val = 1; m0_addr = 14'h0028; m0_rdwn = 0;
      wait_val();
      repeat (2) step();
      rst = 1'b1;
      #1;
      check("t6_rst_val",     o_mci_val, 1'b0);
      check("t6_rst_busy",    o_busy, 1'b0);
      check("t6_rst_m0_ack",  o_m0_ack, 1'b0);
      check("t6_rst_m1_ack",  o_m1_ack, 1'b0);
      check("t6_rst_err_cnt", o_err_cnt, 8'd0);
      m0_val = 0;
      repeat (2) step();
      rst = 1'b0;
      step();
      m1_val = 1; m1_addr = 14'h0030; m1_rdwn = 1;
      serve(2, 32'hC0DE_0006, who, pl);
      check("t6_who",   who, 1);
      check("t6_rdata", o_m1_rdata, 32'hC0DE_0006);
      check("t6_err",   o_m1_err, 1'b0);
      repeat (3) step();

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
